// File: rtl/online_pkg.sv
// Shared definitions for the online-arithmetic operand front-ends:
// digit width, signed-digit encodings and the serializer state type.
package online_pkg;

    localparam int unsigned DIG_W = 2;

    localparam logic [DIG_W-1:0] DIG_ZERO = 2'b00;
    localparam logic [DIG_W-1:0] DIG_POS  = 2'b01;
    localparam logic [DIG_W-1:0] DIG_NEG  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAD   = 2'd2
    } ser_state_e;

endpackage

// File: rtl/online_digit_recode.sv
// Combinational recode of one two's-complement bit into a radix-2 signed digit.
// The sign bit carries negative weight, so a set sign bit becomes -1.
module online_digit_recode
    import online_pkg::*;
(
    input  logic             bit_i,
    input  logic             is_sign_i,
    output logic [DIG_W-1:0] dig_c_o
);

    always_comb begin
        dig_c_o = DIG_ZERO;
        if (bit_i) begin
            dig_c_o = is_sign_i ? DIG_NEG : DIG_POS;
        end
    end

endmodule

// File: rtl/online_digit_serializer.sv
// MSB-first signed-digit serializer feeding the online multiplier delay chain.
// Define ONLINE_SER_PAD_EN to append PAD_DIGITS zero digits after every operand.
module online_digit_serializer
    import online_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PAD_DIGITS = 3
) (
    input  logic              clk,
    input  logic              asyn_reset,
    input  logic              enable,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    output logic [DIG_W-1:0]  dig_out,
    output logic              dig_valid,
    output logic              dig_first,
    output logic              dig_last,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W + PAD_DIGITS + 1);
`ifdef ONLINE_SER_PAD_EN
    localparam int unsigned PAD_EFF = PAD_DIGITS;
`else
    localparam int unsigned PAD_EFF = 0;
`endif
    localparam int unsigned DATA_CNT0 = DATA_W - 1;
    localparam int unsigned PAD_CNT0  = (PAD_EFF > 0) ? PAD_EFF - 1 : 0;
    localparam bit          LOAD_LAST = (DATA_W == 1) && (PAD_EFF == 0);

    ser_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DIG_W-1:0]  dig_out_q, dig_out_d;
    logic              dig_valid_q, dig_valid_d;
    logic              dig_first_q, dig_first_d;
    logic              dig_last_q, dig_last_d;

    logic [DIG_W-1:0]  sign_dig_c;
    logic [DIG_W-1:0]  data_dig_c;
    logic              accept_c;

    // Sign digit comes straight from the offered operand, later digits from the shifter
    online_digit_recode u_recode_sign (
        .bit_i     (load_data[DATA_W-1]),
        .is_sign_i (1'b1),
        .dig_c_o   (sign_dig_c)
    );

    online_digit_recode u_recode_data (
        .bit_i     (sh_q[DATA_W-1]),
        .is_sign_i (1'b0),
        .dig_c_o   (data_dig_c)
    );

    // Ready on the final digit of a frame as well, giving gapless back-to-back frames
    assign load_ready = enable & ((state_q == IDLE) | dig_last_q);
    assign accept_c   = load_valid & load_ready;

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (enable) begin
            unique case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q == '0) begin
`ifdef ONLINE_SER_PAD_EN
                        if (PAD_EFF > 0) begin
                            state_d = PAD;
                        end else begin
                            state_d = accept_c ? SHIFT : IDLE;
                        end
`else
                        state_d = accept_c ? SHIFT : IDLE;
`endif
                    end
                end
`ifdef ONLINE_SER_PAD_EN
                PAD: begin
                    if (cnt_q == '0) begin
                        state_d = accept_c ? SHIFT : IDLE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and registered digit outputs; everything holds while enable is low
    always_comb begin
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        dig_out_d   = dig_out_q;
        dig_valid_d = dig_valid_q;
        dig_first_d = dig_first_q;
        dig_last_d  = dig_last_q;
        if (enable) begin
            dig_out_d   = DIG_ZERO;
            dig_valid_d = 1'b0;
            dig_first_d = 1'b0;
            dig_last_d  = 1'b0;
            if (accept_c) begin
                cnt_d       = CNT_W'(DATA_CNT0);
                sh_d        = load_data << 1;
                dig_out_d   = sign_dig_c;
                dig_valid_d = 1'b1;
                dig_first_d = 1'b1;
                dig_last_d  = LOAD_LAST;
            end else begin
                unique case (state_q)
                    SHIFT: begin
                        if (cnt_q != '0) begin
                            cnt_d       = cnt_q - CNT_W'(1);
                            sh_d        = sh_q << 1;
                            dig_out_d   = data_dig_c;
                            dig_valid_d = 1'b1;
                            dig_last_d  = (PAD_EFF == 0) && (cnt_q == CNT_W'(1));
                        end else if (PAD_EFF > 0) begin
                            cnt_d       = CNT_W'(PAD_CNT0);
                            dig_valid_d = 1'b1;
                            dig_last_d  = (PAD_EFF == 1);
                        end
                    end
`ifdef ONLINE_SER_PAD_EN
                    PAD: begin
                        if (cnt_q != '0) begin
                            cnt_d       = cnt_q - CNT_W'(1);
                            dig_valid_d = 1'b1;
                            dig_last_d  = (cnt_q == CNT_W'(1));
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            cnt_q       <= '0;
            sh_q        <= '0;
            dig_out_q   <= DIG_ZERO;
            dig_valid_q <= 1'b0;
            dig_first_q <= 1'b0;
            dig_last_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            dig_out_q   <= dig_out_d;
            dig_valid_q <= dig_valid_d;
            dig_first_q <= dig_first_d;
            dig_last_q  <= dig_last_d;
        end
    end

    assign dig_out   = dig_out_q;
    assign dig_valid = dig_valid_q;
    assign dig_first = dig_first_q;
    assign dig_last  = dig_last_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_online_digit_serializer.sv
// Bench for online_digit_serializer: directed frames plus random traffic checked
// against a digit-queue reference model; follows ONLINE_SER_PAD_EN like the RTL.
module tb_online_digit_serializer;

    localparam int DW = 8;
    localparam int PD = 3;
`ifdef ONLINE_SER_PAD_EN
    localparam int PE = PD;
`else
    localparam int PE = 0;
`endif

    logic          clk = 1'b0;
    logic          asyn_reset;
    logic          enable;
    logic          load_valid;
    logic          load_ready;
    logic [DW-1:0] load_data;
    logic [1:0]    dig_out;
    logic          dig_valid;
    logic          dig_first;
    logic          dig_last;
    logic          busy;

    online_digit_serializer #(
        .DATA_W     (DW),
        .PAD_DIGITS (PD)
    ) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .dig_out    (dig_out),
        .dig_valid  (dig_valid),
        .dig_first  (dig_first),
        .dig_last   (dig_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the remaining digits of the current frame and the digit on show
    int            m_q[$];
    bit            m_valid = 1'b0;
    int            m_d     = 0;
    bit            m_first = 1'b0;
    bit            m_last  = 1'b0;
    int            m_idx   = 0;
    logic [DW-1:0] m_op    = '0;
    bit            m_acc   = 1'b0;
    int            acc     = 0;

    function automatic logic [1:0] enc(input int d);
        if (d == 1)  return 2'b01;
        if (d == -1) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int dec(input logic [1:0] x);
        if (x == 2'b01) return 1;
        if (x == 2'b10) return -1;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_digits(input logic [DW-1:0] op);
        m_q.delete();
        m_q.push_back(op[DW-1] ? -1 : 0);
        for (int i = DW - 2; i >= 0; i--) m_q.push_back(op[i] ? 1 : 0);
        for (int i = 0; i < PE; i++) m_q.push_back(0);
    endtask

    task automatic check_out();
        chk("dig_valid", 32'(dig_valid), 32'(m_valid));
        chk("dig_out",   32'(dig_out),   32'(enc(m_d)));
        chk("dig_first", 32'(dig_first), 32'(m_first));
        chk("dig_last",  32'(dig_last),  32'(m_last));
        chk("busy",      32'(busy),      32'(m_valid));
    endtask

    // One clock: drive inputs, check ready, advance model at the edge, check outputs
    task automatic cyc(input bit en, input bit lv, input logic [DW-1:0] ld);
        asyn_reset = 1'b0;
        enable     = en;
        load_valid = lv;
        load_data  = ld;
        #1;
        chk("load_ready", 32'(load_ready), 32'(en && (!m_valid || m_last)));
        m_acc = en && lv && (!m_valid || m_last);
        @(posedge clk);
        if (en) begin
            if (m_acc) begin
                load_digits(ld);
                m_op    = ld;
                m_idx   = 0;
                m_d     = m_q.pop_front();
                m_valid = 1'b1;
                acc     = 0;
            end else if (m_valid && m_q.size() > 0) begin
                m_idx++;
                m_d = m_q.pop_front();
            end else begin
                m_valid = 1'b0;
                m_d     = 0;
            end
            m_first = m_valid && (m_idx == 0);
            m_last  = m_valid && (m_q.size() == 0);
        end
        #1;
        check_out();
        if (en && m_valid && m_idx < DW) begin
            acc += dec(dig_out) * (1 << (DW - 1 - m_idx));
            if (m_idx == DW - 1) chk("frame_value", 32'(acc), 32'(int'($signed(m_op))));
        end
    endtask

    // Assert reset between edges and confirm outputs clear without a clock
    task automatic hit_reset();
        #3;
        asyn_reset = 1'b1;
        #1;
        m_q.delete();
        m_valid = 1'b0;
        m_d     = 0;
        m_first = 1'b0;
        m_last  = 1'b0;
        check_out();
        @(posedge clk);
        #1;
        check_out();
        asyn_reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < DW + PE + 2; i++) cyc(1'b1, 1'b0, DW'($urandom));
    endtask

    initial begin
        asyn_reset = 1'b1;
        enable     = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        #2;
        check_out();
        chk("reset_load_ready", 32'(load_ready), 32'd1);
        @(posedge clk);
        #1;
        asyn_reset = 1'b0;

        // Idle hold with random data on the bus
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, DW'($urandom));

        // Single frame -93
        cyc(1'b1, 1'b1, 8'hA3);
        drain();

        // Back-to-back 7F then 80, load_valid held until 80 is taken
        cyc(1'b1, 1'b1, 8'h7F);
        for (int g = 0; g < 40; g++) begin
            cyc(1'b1, 1'b1, 8'h80);
            if (m_acc) break;
        end
        chk("b2b_accepted", 32'(m_acc), 32'd1);
        drain();

        // Stall for 4 cycles after the 3rd digit, with an operand offered meanwhile
        cyc(1'b1, 1'b1, 8'h5A);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'hFF);
        drain();

        // Reset during digit 5, then a fresh load
        cyc(1'b1, 1'b1, 8'hC6);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'h00);
        hit_reset();
        cyc(1'b1, 1'b1, 8'h3C);
        drain();

        // Extremes and single-bit operands
        cyc(1'b1, 1'b1, 8'h01);
        drain();
        cyc(1'b1, 1'b1, 8'hFF);
        drain();

        // Random traffic with stalls and occasional resets
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) hit_reset();
            else cyc($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, DW'($urandom));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
